// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/sequencing stage: instruction classes,
// control opcodes, error codes, FSM states and control-field positions.
package fetch_unit_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;

  // Instruction field positions
  localparam int unsigned CLS_MSB = 31;
  localparam int unsigned CLS_LSB = 28;
  localparam int unsigned OPC_MSB = 27;
  localparam int unsigned OPC_LSB = 25;
  localparam int unsigned TGT_MSB = 22;
  localparam int unsigned TGT_LSB = 13;

  // Instruction classes
  localparam logic [3:0] CLS_ALU   = 4'd1;
  localparam logic [3:0] CLS_CTRL  = 4'd2;
  localparam logic [3:0] CLS_MEM   = 4'd4;
  localparam logic [3:0] CLS_CONST = 4'd8;

  // Control opcodes
  typedef enum logic [2:0] {
    OP_BUN = 3'd0,
    OP_BSA = 3'd1,
    OP_RET = 3'd2,
    OP_HLT = 3'd3,
    OP_SIZ = 3'd4,
    OP_SNZ = 3'd5,
    OP_SIV = 3'd6,
    OP_SNV = 3'd7
  } ctrlOp_e;

  // Error codes
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_SKIPWAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALT     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

  // Classes that are forwarded to the execute stage
  function automatic logic isIssuable(input logic [3:0] cls);
    return (cls == CLS_ALU) || (cls == CLS_MEM) || (cls == CLS_CONST);
  endfunction

  // Skip condition of a conditional-skip opcode against the final flags
  function automatic logic skipHit(input ctrlOp_e op, input logic z, input logic v);
    case (op)
      OP_SIZ:  return z;
      OP_SNZ:  return !z;
      OP_SIV:  return v;
      OP_SNV:  return !v;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Hardware return stack for BSA/RET; push is dropped when full, pop when empty.
module ret_stack
  import fetch_unit_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem [RS_DEPTH];
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] topIdx;

  assign full   = (count == CNT_W'(RS_DEPTH));
  assign empty  = (count == '0);
  assign topIdx = PTR_W'(count - CNT_W'(1));
  assign dout   = mem[topIdx];

  // Occupancy counter; clear wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage, written at the current fill level
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[count[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage: resolves control flow locally and
// issues ALU/MEM/CONST instructions to execute over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [9:0]  RESET_VEC = 10'd0,
  parameter int unsigned RS_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imReDat_addr,
  input  logic [INSTR_W-1:0] imReDat,
  output logic [INSTR_W-1:0] issInstr,
  output logic               issValid,
  input  logic               issReady,
  input  logic               exIdle,
  input  logic               flagZ,
  input  logic               flagV,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               err,
  output logic [1:0]         errCode
);

  state_e               state, stateNxt;
  logic [PC_W-1:0]      pcNxt;
  logic [INSTR_W-1:0]   issInstrNxt;
  logic                 issValidNxt;
  logic                 haltedNxt;
  logic                 errNxt;
  logic [1:0]           errCodeNxt;

  logic [3:0]           cls;
  ctrlOp_e              opc;
  logic [PC_W-1:0]      target;
  logic [PC_W-1:0]      pcInc;
  logic [PC_W-1:0]      pcSkip;
  logic                 slotFree;
  logic                 drained;

  logic                 stPush, stPop, stClr;
  logic [PC_W-1:0]      stDout;
  logic                 stFull, stEmpty;

  assign imReDat_addr = pc;
  assign cls          = imReDat[CLS_MSB:CLS_LSB];
  assign opc          = ctrlOp_e'(imReDat[OPC_MSB:OPC_LSB]);
  assign target       = imReDat[TGT_MSB:TGT_LSB];
  assign pcInc        = pc + PC_W'(1);
  assign pcSkip       = pc + PC_W'(2);
  assign slotFree     = !issValid || issReady;
  assign drained      = !issValid && exIdle;

  ret_stack #(
    .RS_DEPTH (RS_DEPTH)
  ) u_retStack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stClr),
    .push  (stPush),
    .pop   (stPop),
    .din   (pcInc),
    .dout  (stDout),
    .full  (stFull),
    .empty (stEmpty)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_VEC;
      issInstr <= '0;
      issValid <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      errCode  <= ERR_NONE;
    end else begin
      state    <= stateNxt;
      pc       <= pcNxt;
      issInstr <= issInstrNxt;
      issValid <= issValidNxt;
      halted   <= haltedNxt;
      err      <= errNxt;
      errCode  <= errCodeNxt;
    end
  end

  // Next-state, PC sequencing, issue slot and return-stack control
  always_comb begin
    stateNxt    = state;
    pcNxt       = pc;
    issInstrNxt = issInstr;
    issValidNxt = issValid;
    haltedNxt   = halted;
    errNxt      = err;
    errCodeNxt  = errCode;
    stPush      = 1'b0;
    stPop       = 1'b0;
    stClr       = 1'b0;

    // An accepted slot empties unless refilled below, in every state
    if (issValid && issReady) begin
      issValidNxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          stateNxt = ST_RUN;
          pcNxt    = RESET_VEC;
        end
      end

      ST_RUN: begin
        if (isIssuable(cls)) begin
          if (slotFree) begin
            issInstrNxt = imReDat;
            issValidNxt = 1'b1;
            pcNxt       = pcInc;
          end
        end else if (cls == CLS_CTRL) begin
          case (opc)
            OP_BUN: pcNxt = target;
            OP_BSA: begin
              if (stFull) begin
                stateNxt   = ST_ERROR;
                errNxt     = 1'b1;
                errCodeNxt = ERR_OVERFLOW;
              end else begin
                stPush = 1'b1;
                pcNxt  = target;
              end
            end
            OP_RET: begin
              if (stEmpty) begin
                stateNxt   = ST_ERROR;
                errNxt     = 1'b1;
                errCodeNxt = ERR_UNDERFLOW;
              end else begin
                stPop = 1'b1;
                pcNxt = stDout;
              end
            end
            OP_HLT:  stateNxt = ST_DRAIN;
            default: stateNxt = ST_SKIPWAIT;
          endcase
        end else begin
          stateNxt   = ST_ERROR;
          errNxt     = 1'b1;
          errCodeNxt = ERR_ILLEGAL;
        end
      end

      // Opcode is re-read from IM: pc still addresses the skip instruction
      ST_SKIPWAIT: begin
        if (drained) begin
          stateNxt = ST_RUN;
          pcNxt    = skipHit(opc, flagZ, flagV) ? pcSkip : pcInc;
        end
      end

      ST_DRAIN: begin
        if (drained) begin
          stateNxt  = ST_HALT;
          haltedNxt = 1'b1;
        end
      end

      ST_HALT, ST_ERROR: begin
        if (start) begin
          stateNxt   = ST_RUN;
          pcNxt      = RESET_VEC;
          stClr      = 1'b1;
          haltedNxt  = 1'b0;
          errNxt     = 1'b0;
          errCodeNxt = ERR_NONE;
        end
      end

      default: stateNxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus random
// programs compared against an instruction-level interpreter.
module tb_fetch_unit;

  localparam logic [9:0] RV    = 10'd1000;
  localparam int         DEPTH = 8;
  localparam int BUN = 0, BSA = 1, RET = 2, HLT = 3, SIZ = 4, SNZ = 5, SIV = 6, SNV = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  imReDat_addr;
  logic [31:0] imReDat;
  logic [31:0] issInstr;
  logic        issValid;
  logic        issReady = 1'b1;
  logic        exIdle = 1'b0;
  logic        flagZ = 1'b0;
  logic        flagV = 1'b0;
  logic [9:0]  pc;
  logic        halted;
  logic        err;
  logic [1:0]  errCode;

  logic [31:0] im [1024];
  assign imReDat = im[imReDat_addr];

  fetch_unit #(.RESET_VEC(RV), .RS_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imReDat_addr (imReDat_addr),
    .imReDat      (imReDat),
    .issInstr     (issInstr),
    .issValid     (issValid),
    .issReady     (issReady),
    .exIdle       (exIdle),
    .flagZ        (flagZ),
    .flagV        (flagV),
    .pc           (pc),
    .halted       (halted),
    .err          (err),
    .errCode      (errCode)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  logic [31:0] expQ[$];
  logic [31:0] obsQ[$];
  bit          expHalt;
  logic [1:0]  expCode;
  logic [9:0]  expPc;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mkCtrl(input int op, input logic [9:0] tgt);
    return {4'd2, 3'(op), 2'b00, tgt, 13'd0};
  endfunction

  function automatic logic [31:0] mkOp(input logic [3:0] cls, input int payload);
    return {cls, 28'(payload)};
  endfunction

  function automatic logic [9:0] at(input int off);
    return 10'(int'(RV) + off);
  endfunction

  task automatic fillHlt();
    for (int i = 0; i < 1024; i++) im[i] = mkCtrl(HLT, 10'd0);
  endtask

  // Architectural interpreter: walks the program, collecting the issue stream
  task automatic modelRun(input bit fz, input bit fv, output bit done);
    logic [9:0]  p;
    logic [9:0]  stk[$];
    logic [31:0] w;
    bit          taken;
    int          op;
    p = RV; done = 1'b0; expHalt = 1'b0; expCode = 2'd0;
    expQ.delete();
    for (int s = 0; s < 400 && !done; s++) begin
      w  = im[p];
      op = int'(w[27:25]);
      case (w[31:28])
        4'd1, 4'd4, 4'd8: begin expQ.push_back(w); p = p + 10'd1; end
        4'd2: begin
          if (op == BUN) p = w[22:13];
          else if (op == BSA) begin
            if (stk.size() >= DEPTH) begin expCode = 2'd2; done = 1'b1; end
            else begin stk.push_back(p + 10'd1); p = w[22:13]; end
          end else if (op == RET) begin
            if (stk.size() == 0) begin expCode = 2'd3; done = 1'b1; end
            else p = stk.pop_back();
          end else if (op == HLT) begin expHalt = 1'b1; done = 1'b1; end
          else begin
            taken = (op == SIZ) ? fz : (op == SNZ) ? !fz : (op == SIV) ? fv : !fv;
            p = p + (taken ? 10'd2 : 10'd1);
          end
        end
        default: begin expCode = 2'd1; done = 1'b1; end
      endcase
    end
    expPc = p;
  endtask

  // Start pulse; one cycle later the DUT is in RUN at RESET_VEC with status cleared
  task automatic pulseStart(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkVal({tag, "_startPc"}, 32'(pc), 32'(RV));
    checkVal({tag, "_startErr"}, {29'd0, err, errCode}, 32'd0);
    checkVal({tag, "_startHalt"}, 32'(halted), 32'd0);
  endtask

  // Run the loaded program to completion and compare with the interpreter
  task automatic runProgram(input string tag, input bit randHs, input bit fz, input bit fv);
    bit          done;
    bit          fin;
    logic        pv, pr;
    logic [31:0] pi;
    int          n;
    modelRun(fz, fv, done);
    flagZ = fz; flagV = fv;
    issReady = 1'b1; exIdle = 1'b0;
    obsQ.delete();
    pulseStart(tag);
    fin = 1'b0; pv = 1'b0; pr = 1'b1; pi = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      issReady = randHs ? ($urandom_range(0, 3) != 0) : 1'b1;
      exIdle   = ($urandom_range(0, 2) != 0);
      #1;
      if (pv && !pr) begin
        checkVal({tag, "_stableValid"}, 32'(issValid), 32'd1);
        checkVal({tag, "_stableInstr"}, issInstr, pi);
      end
      pv = issValid; pr = issReady; pi = issInstr;
      if (issValid && issReady) obsQ.push_back(issInstr);
      if ((halted || err) && !issValid) fin = 1'b1;
      else @(negedge clk);
    end
    checkVal({tag, "_finished"}, 32'(fin), 32'd1);
    checkVal({tag, "_issueCount"}, 32'(obsQ.size()), 32'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkVal($sformatf("%s_issue%0d", tag, i), obsQ[i], expQ[i]);
    checkVal({tag, "_halted"}, 32'(halted), 32'(expHalt));
    checkVal({tag, "_err"}, 32'(err), 32'(expCode != 2'd0));
    checkVal({tag, "_errCode"}, 32'(errCode), 32'(expCode));
    checkVal({tag, "_pc"}, 32'(pc), 32'(expPc));
  endtask

  task automatic loadProgA();
    fillHlt();
    im[at(0)] = mkOp(4'd8, 'h11);
    im[at(1)] = mkOp(4'd8, 'h22);
    im[at(2)] = mkOp(4'd1, 'h5);
    im[at(3)] = mkCtrl(SNZ, 10'd0);
    im[at(4)] = mkCtrl(BSA, 10'd100);
    im[at(5)] = mkOp(4'd4, 'h300);
    im[at(6)] = mkCtrl(HLT, 10'd0);
    im[100]   = mkOp(4'd4, 'h777);
    im[101]   = mkCtrl(RET, 10'd0);
  endtask

  // Cycle-exact walk of program A with flagZ=0
  task automatic dirTimingA();
    loadProgA();
    flagZ = 1'b0; flagV = 1'b0; issReady = 1'b1; exIdle = 1'b0;
    pulseStart("tA");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal($sformatf("tA_valid%0d", i), 32'(issValid), 32'd1);
      checkVal($sformatf("tA_instr%0d", i), issInstr, im[at(i)]);
      checkVal($sformatf("tA_pc%0d", i), 32'(pc), 32'(at(i + 1)));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal($sformatf("tA_skipWaitValid%0d", i), 32'(issValid), 32'd0);
      checkVal($sformatf("tA_skipWaitPc%0d", i), 32'(pc), 32'(at(3)));
    end
    exIdle = 1'b1;
    @(negedge clk);
    checkVal("tA_skipPc", 32'(pc), 32'(at(5)));
    @(negedge clk);
    checkVal("tA_im5Valid", 32'(issValid), 32'd1);
    checkVal("tA_im5Instr", issInstr, im[at(5)]);
    @(negedge clk);
    checkVal("tA_drainHalted", 32'(halted), 32'd0);
    @(negedge clk);
    checkVal("tA_halted", 32'(halted), 32'd1);
    checkVal("tA_haltPc", 32'(pc), 32'(at(6)));
  endtask

  // Three-cycle back-pressure with a full slot
  task automatic dirStall();
    fillHlt();
    for (int i = 0; i < 6; i++) im[at(i)] = mkOp(4'd8, i + 1);
    issReady = 1'b0; exIdle = 1'b1;
    pulseStart("st");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkVal($sformatf("st_holdValid%0d", i), 32'(issValid), 32'd1);
      checkVal($sformatf("st_holdInstr%0d", i), issInstr, im[at(0)]);
      checkVal($sformatf("st_holdPc%0d", i), 32'(pc), 32'(at(1)));
    end
    issReady = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      checkVal($sformatf("st_resumeInstr%0d", i), issInstr, im[at(i)]);
      checkVal($sformatf("st_resumePc%0d", i), 32'(pc), 32'(at(i + 1)));
    end
    for (int c = 0; c < 50 && !halted; c++) @(negedge clk);
    checkVal("st_halted", 32'(halted), 32'd1);
  endtask

  // Asynchronous reset in the middle of issuing
  task automatic dirResetMid();
    fillHlt();
    for (int i = 0; i < 30; i++) im[at(i)] = mkOp(4'd4, 'h40 + i);
    issReady = 1'b1; exIdle = 1'b1;
    pulseStart("rm");
    repeat (3) @(negedge clk);
    checkVal("rm_preValid", 32'(issValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("rm_valid", 32'(issValid), 32'd0);
    checkVal("rm_instr", issInstr, 32'd0);
    checkVal("rm_pc", 32'(pc), 32'(RV));
    checkVal("rm_status", {29'd0, halted, err, errCode[0] | errCode[1]}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal($sformatf("rm_idleValid%0d", i), 32'(issValid), 32'd0);
      checkVal($sformatf("rm_idlePc%0d", i), 32'(pc), 32'(RV));
    end
  endtask

  function automatic logic [31:0] randWord(input int i);
    int r;
    int op;
    logic [3:0] bad [10] = '{4'd0, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd14, 4'd15};
    logic [3:0] good [3] = '{4'd1, 4'd4, 4'd8};
    r = int'($urandom_range(0, 99));
    if (r < 60) return {good[$urandom_range(0, 2)], 28'($urandom)};
    if (r < 96) begin
      op = int'($urandom_range(0, 7));
      if (op == BUN || op == BSA) return mkCtrl(op, at(i + 1 + int'($urandom_range(0, 6))));
      return mkCtrl(op, 10'($urandom));
    end
    return {bad[$urandom_range(0, 9)], 28'($urandom)};
  endfunction

  initial begin
    bit done;
    bit fz, fv;
    fillHlt();
    repeat (2) @(negedge clk);
    checkVal("rst_valid", 32'(issValid), 32'd0);
    checkVal("rst_instr", issInstr, 32'd0);
    checkVal("rst_pc", 32'(pc), 32'(RV));
    checkVal("rst_addr", 32'(imReDat_addr), 32'(RV));
    checkVal("rst_status", {29'd0, halted, err, errCode[0] | errCode[1]}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("idle_valid", 32'(issValid), 32'd0);
    checkVal("idle_pc", 32'(pc), 32'(RV));

    dirTimingA();
    loadProgA();
    runProgram("progA_z1", 1'b0, 1'b1, 1'b0);
    runProgram("progA_z0_rand", 1'b1, 1'b0, 1'b0);
    dirStall();

    fillHlt();
    for (int i = 0; i <= DEPTH; i++) im[at(i)] = mkCtrl(BSA, at(i + 1));
    runProgram("overflow", 1'b1, 1'b0, 1'b0);

    fillHlt();
    im[at(0)] = mkOp(4'd8, 'h9);
    im[at(1)] = mkCtrl(RET, 10'd0);
    runProgram("underflow", 1'b1, 1'b0, 1'b0);

    fillHlt();
    im[at(0)] = mkOp(4'd8, 'h1);
    im[at(1)] = mkOp(4'd1, 'h2);
    im[at(2)] = 32'h0000_0000;
    runProgram("illegal", 1'b1, 1'b0, 1'b0);

    fillHlt();
    im[at(0)] = mkCtrl(BUN, 10'd1023);
    im[1023]  = mkOp(4'd8, 'hC0);
    im[0]     = mkCtrl(SNZ, 10'd0);
    im[1]     = mkOp(4'd8, 'hBAD);
    im[2]     = mkOp(4'd8, 'hABC);
    runProgram("wrap", 1'b1, 1'b0, 1'b0);

    dirResetMid();

    for (int r = 0; r < 30; r++) begin
      fz = 1'($urandom);
      fv = 1'($urandom);
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        fillHlt();
        for (int i = 0; i < 40; i++) im[at(i)] = randWord(i);
        modelRun(fz, fv, done);
      end
      if (done) runProgram($sformatf("rand%0d", r), 1'b1, fz, fv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and sequencing stage that sits directly upstream of the execute stage and drives the instruction memory read port.
- Holds the PC and drives imReDat_addr; imReDat returns combinationally in the same cycle.
- Resolves all CONTROL-class instructions locally: BUN, BSA, RET, HLT, SIZ, SNZ, SIV and SNV. It owns a hardware return stack.
- Issues ALU, MEM and CONST instructions downstream through a valid/ready handshake.

Parameters:
RESET_VEC, 0, start PC after reset/restart (10-bit)
RS_DEPTH, 8, return-stack entries (power of 2, ≥2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE/HALT/ERROR and runs from RESET_VEC
imReDat_addr  out  10  IM read address (= pc, combinational)
imReDat  in  32  IM read data for imReDat_addr, same cycle
issInstr  out  32  instruction presented to execute stage
issValid  out  1  issInstr valid
issReady  in  1  execute accepts issInstr this cycle
exIdle  in  1  execute stage has nothing in flight; flags final
flagZ  in  1  zero flag from ALU
flagV  in  1  overflow flag from ALU
pc  out  10  current PC (debug)
halted  out  1  HLT retired, pipeline drained
err  out  1  sticky error
errCode  out  2  0 none, 1 illegal class, 2 stack overflow, 3 stack underflow

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, pc=RESET_VEC, stack empty, issValid=0, issInstr=0, halted=0, err=0, errCode=0.
- States: IDLE, RUN, SKIPWAIT, DRAIN, HALT, ERROR.
- IDLE: start → RUN. HALT/ERROR: start → RUN with pc=RESET_VEC, stack emptied, err, errCode and halted cleared. start while in RUN, SKIPWAIT or DRAIN is ignored.
- Slot: the issue register is "free" when issValid=0 or issReady=1 in that cycle. Class = imReDat[31:28].
- RUN, class 1/4/8 (ALU/MEM/CONST), slot free: issInstr←imReDat, issValid←1, pc←pc+1. Slot not free: hold pc and the slot. Throughput is 1 instruction/cycle. The first issValid rises 1 cycle after entering RUN.
- RUN, slot accepted with no new load: issValid←0.
- RUN, class 2 (control), opcode = imReDat[27:25], target = imReDat[22:13] (bits [24:23] ignored). Control instructions are never issued downstream. Each completes in 1 cycle and does not wait for the slot, except skips.
  - BUN: pc←target.
  - BSA: push pc+1, pc←target. If the stack is full → ERROR, code 2, no push.
  - RET: pc←pop. If the stack is empty → ERROR, code 3.
  - HLT: → DRAIN. pc is unchanged.
  - SIZ/SNZ/SIV/SNV: → SKIPWAIT. pc is unchanged.
- SKIPWAIT: wait until issValid=0 and exIdle=1, then evaluate in that cycle. SIZ skips if flagZ=1; SNZ if flagZ=0; SIV if flagV=1; SNV if flagV=0. Skip → pc+2, else pc+1. Return to RUN.
- DRAIN: wait until issValid=0 and exIdle=1 → HALT, halted=1.
- Any other class (0,3,5,6,7,9–15) in RUN → ERROR, code 1. The pending slot still completes its handshake; no new issue.
- ERROR: err=1 and errCode are held until start or reset. No further fetch.
- PC arithmetic is modulo 1024: 1023+1→0, and a skip at 1022→0, at 1023→1. A return address of 1023+1 is pushed as 0.
- issInstr and issValid are stable while issValid=1 and issReady=0.
- Simultaneous push/pop never occurs (one control instruction per cycle).

Decomposition:
- Shared package holds:
  - class codes: ALU=1, CTRL=2, MEM=4, CONST=8
  - control opcodes 0–7
  - errCode values
  - FSM state enum
  - control-instruction field positions
- Sub-module ret_stack (parameter RS_DEPTH): push, pop, din/dout 10-bit, full, empty, async active-low reset to empty.

Test Plan:
- Program: IM0 const, IM1 const, IM2 ALU SUB, IM3 SNZ, IM4 BSA 100, IM5 MEM load, IM6 HLT; issReady=1, flagZ=0 at SKIPWAIT. Expected: issues IM0, IM1, IM2 on consecutive cycles; SKIPWAIT until exIdle=1; pc→5; IM5 issued; halted=1 after drain. IM4 is never executed.
- Same program with flagZ=1. Expected: BSA pushes 5, pc=100; IM100 store issued; IM101 RET → pc=5; IM5 issued; halted=1; stack empty at end.
- issReady held low 3 cycles with the slot full. Expected: issInstr stable, pc frozen, then resumes 1/cycle when issReady=1.
- RS_DEPTH+1 nested BSA. Expected: err=1, errCode=2. RET at an empty stack: errCode=3. Word 0x00000000 fetched: errCode=1. In each case start recovers from RESET_VEC.
- BUN to 1023, which holds const, then an SNZ at 0 with flagZ=0. Expected: pc wraps 1023→0, and the skip lands at pc=2.
- rst_n asserted low mid-RUN with issValid=1. Expected: immediately issValid=0, pc=RESET_VEC, state IDLE, and no fetch until start.
